// File: rtl/cordic_vector.sv
// rtl/cordic_vector.sv - iterative vectoring-mode CORDIC returning magnitude and atan2(y, x)
// Optional gain-compensation stage (COMP state) is built when CORDIC_GAIN_COMP_EN is defined.
module cordic_vector #(
    parameter int ITER = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x_in,
    input  logic [31:0] y_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] mag_out,
    output logic [31:0] ang_out
);

    localparam logic [31:0] POS_PI = 32'h6487ED51;
    localparam logic [31:0] NEG_PI = 32'h9B7812AF;
    localparam logic [4:0]  LAST_I = 5'(ITER - 1);

`ifdef CORDIC_GAIN_COMP_EN
    localparam logic signed [32:0] GAIN_K = 33'sh4DBA76D4;
    localparam logic signed [65:0] ROUND_HALF = 66'sh40000000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_ITER = 3'd2,
        S_COMP = 3'd3,
        S_DONE = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_ITER = 3'd2,
        S_DONE = 3'd4
    } state_t;
`endif

    state_t state_q, state_d;

    logic signed [33:0] x_q, x_d;
    logic signed [33:0] y_q, y_d;
    logic signed [31:0] z_q, z_d;
    logic [4:0]         i_q, i_d;
    logic               zero_q, zero_d;

    logic signed [33:0] x_shift;
    logic signed [33:0] y_shift;

`ifdef CORDIC_GAIN_COMP_EN
    logic signed [65:0] prod_full;
    logic signed [65:0] prod_rnd;
    logic               unused_prod;
`endif

    // Q3.29 atan(2^-i); beyond i=9 the value rounds to exactly 2^(29-i)
    function automatic logic signed [31:0] atan_rom(input logic [4:0] idx);
        case (idx)
            5'd0:    atan_rom = 32'sh1921FB54;
            5'd1:    atan_rom = 32'sh0ED63383;
            5'd2:    atan_rom = 32'sh07D6DD7E;
            5'd3:    atan_rom = 32'sh03FAB753;
            5'd4:    atan_rom = 32'sh01FF55BB;
            5'd5:    atan_rom = 32'sh00FFEAAE;
            5'd6:    atan_rom = 32'sh007FFD55;
            5'd7:    atan_rom = 32'sh003FFFAB;
            5'd8:    atan_rom = 32'sh001FFFF5;
            5'd9:    atan_rom = 32'sh000FFFFF;
            default: atan_rom = 32'sh20000000 >>> idx;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = S_PRE;
            S_PRE:  state_d = S_ITER;
            S_ITER: begin
                if (i_q == LAST_I) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_d = S_COMP;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef CORDIC_GAIN_COMP_EN
            S_COMP: state_d = S_DONE;
`endif
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            i_q    <= '0;
            zero_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            z_q    <= z_d;
            i_q    <= i_d;
            zero_q <= zero_d;
        end
    end

`ifdef CORDIC_GAIN_COMP_EN
    always_comb begin
        prod_full   = x_q * GAIN_K;
        prod_rnd    = prod_full + ROUND_HALF;
        unused_prod = ^{prod_rnd[65], prod_rnd[30:0]};
    end
`endif

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        zero_d  = zero_q;
        x_shift = x_q >>> i_q;
        y_shift = y_q >>> i_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d    = {{2{x_in[31]}}, x_in};
                    y_d    = {{2{y_in[31]}}, y_in};
                    z_d    = '0;
                    zero_d = (x_in == 32'd0) && (y_in == 32'd0);
                end
            end
            S_PRE: begin
                i_d = '0;
                // Fold the left half-plane onto the right; the sign of the original y picks +pi or -pi
                if (x_q[33]) begin
                    x_d = -x_q;
                    y_d = -y_q;
                    z_d = y_q[33] ? NEG_PI : POS_PI;
                end else begin
                    z_d = '0;
                end
            end
            S_ITER: begin
                i_d = i_q + 5'd1;
                if (!y_q[33]) begin
                    x_d = x_q + y_shift;
                    y_d = y_q - x_shift;
                    if (!zero_q) z_d = z_q + atan_rom(i_q);
                end else begin
                    x_d = x_q - y_shift;
                    y_d = y_q + x_shift;
                    if (!zero_q) z_d = z_q - atan_rom(i_q);
                end
            end
`ifdef CORDIC_GAIN_COMP_EN
            S_COMP: x_d = prod_rnd[64:31];
`endif
            default: ;
        endcase
    end

    always_comb begin
        if (x_q[33]) begin
            mag_out = '0;
        end else if (|x_q[32:31]) begin
            mag_out = 32'h7FFFFFFF;
        end else begin
            mag_out = {1'b0, x_q[30:0]};
        end
        ang_out = z_q;
    end

endmodule
